// File: rtl/classify_dispatcher_pkg.sv
// Shared types for the classifier ingress path: packet/rule records, dispatcher
// defaults and the dispatcher FSM encoding.
package classify_dispatcher_pkg;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] dst_port;
        logic [7:0]  proto;
    } packet_s;

    // weight == all-ones is the classifier's "no rule matched" sentinel
    typedef struct packed {
        logic [7:0]  rule_id;
        logic [7:0]  action;
        logic [15:0] weight;
    } rule_s;

    localparam int DISPATCH_FIFO_DEPTH = 8;
    localparam int DISPATCH_SEQ_W      = 16;
    localparam int DISPATCH_TIMEOUT    = 512;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_EMIT
    } dispatch_state_e;

endpackage

// File: rtl/dispatch_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two so the
// pointers wrap naturally.
module dispatch_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr, rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign wr      = push && !full;
    assign rd      = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/classify_dispatcher.sv
// Buffers incoming packets, issues them one at a time to the tree classifier
// and returns each matched rule as a tagged result, with a watchdog abort.
module classify_dispatcher
    import classify_dispatcher_pkg::*;
#(
    parameter int FIFO_DEPTH     = DISPATCH_FIFO_DEPTH,
    parameter int SEQ_W          = DISPATCH_SEQ_W,
    parameter int TIMEOUT_CYCLES = DISPATCH_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  packet_s                       in_packet,
    output logic                          cls_valid,
    output packet_s                       cls_packet,
    input  logic                          cls_ready,
    input  rule_s                         cls_rule,
    output logic                          cls_reset,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SEQ_W-1:0]              out_seq,
    output rule_s                         out_rule,
    output logic                          out_hit,
    output logic                          out_timeout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        packet_s          pkt;
    } entry_t;

    dispatch_state_e  state, state_nxt;
    entry_t           wr_entry, head;
    logic             full, empty, push, pop;
    logic [SEQ_W-1:0] wr_tag, cur_tag;
    logic [WDW-1:0]   wd_cnt;
    logic             waiting, wd_fire, done;

    assign in_ready = !reset && !full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == S_ISSUE);
    assign wr_entry = '{seq: wr_tag, pkt: in_packet};

    dispatch_fifo #(
        .DEPTH(FIFO_DEPTH),
        .W    ($bits(entry_t))
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .wr_data(wr_entry),
        .pop    (pop),
        .rd_data(head),
        .count  (fifo_count),
        .full   (full),
        .empty  (empty)
    );

    // wd_cnt holds cycles since issue, so the abort lands TIMEOUT_CYCLES after cls_valid
    assign waiting = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
    assign wd_fire = waiting && (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));
    assign done    = (state == S_WAIT_DONE) && cls_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (!empty && cls_ready) state_nxt = S_ISSUE;
            S_ISSUE:     state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (wd_fire)         state_nxt = S_EMIT;
                else if (!cls_ready) state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: if (cls_ready || wd_fire) state_nxt = S_EMIT;
            S_EMIT:      if (out_ready) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cls_valid   <= 1'b0;
            cls_packet  <= '0;
            cls_reset   <= 1'b0;
            out_valid   <= 1'b0;
            out_seq     <= '0;
            out_rule    <= '0;
            out_hit     <= 1'b0;
            out_timeout <= 1'b0;
            wr_tag      <= '0;
            cur_tag     <= '0;
            wd_cnt      <= '0;
        end else begin
            cls_valid <= (state_nxt == S_ISSUE);
            cls_reset <= wd_fire && !done;
            out_valid <= (state_nxt == S_EMIT);
            if (push) wr_tag <= wr_tag + 1'b1;
            if (state_nxt == S_ISSUE) cls_packet <= head.pkt;
            if (state == S_ISSUE) begin
                cur_tag <= head.seq;
                wd_cnt  <= WDW'(1);
            end else if (waiting) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            // a result arriving on the watchdog's last cycle still wins
            if (done) begin
                out_rule    <= cls_rule;
                out_hit     <= (cls_rule.weight != '1);
                out_timeout <= 1'b0;
                out_seq     <= cur_tag;
            end else if (wd_fire) begin
                out_rule    <= '0;
                out_hit     <= 1'b0;
                out_timeout <= 1'b1;
                out_seq     <= cur_tag;
            end
        end
    end

endmodule

// File: tb/tb_classify_dispatcher.sv
// Directed bench for classify_dispatcher with a queue-based reference model and
// a behavioural classifier driven from the same negedge process.
`timescale 1ns/1ps
module tb_classify_dispatcher;
    import classify_dispatcher_pkg::*;

    localparam int TO = 16;

    typedef struct packed { logic [15:0] seq; packet_s pkt; } ent_t;
    typedef struct packed { logic [15:0] seq; rule_s rule; logic hit; logic to; } res_t;

    logic    clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1, cls_ready = 1'b1;
    packet_s in_packet = '0;
    rule_s   cls_rule = '0;
    logic    in_ready, cls_valid, cls_reset, out_valid, out_hit, out_timeout;
    packet_s cls_packet;
    rule_s   out_rule;
    logic [15:0] out_seq;
    logic [3:0]  fifo_count;

    classify_dispatcher #(.FIFO_DEPTH(8), .SEQ_W(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_packet(in_packet),
        .cls_valid(cls_valid), .cls_packet(cls_packet), .cls_ready(cls_ready),
        .cls_rule(cls_rule), .cls_reset(cls_reset),
        .out_valid(out_valid), .out_ready(out_ready), .out_seq(out_seq),
        .out_rule(out_rule), .out_hit(out_hit), .out_timeout(out_timeout),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int checks = 0, passes = 0;
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // reference model state
    ent_t  mq[$];
    res_t  eq[$];
    int    cyc = 0;
    logic  rst_q = 1'b1;
    logic [15:0] wr_tag = '0;
    int    cls_delay = 5, rec_delay = 4;
    logic  never_ret = 1'b0, stall = 1'b0;
    rule_s mode_rule = '0;
    logic  busy = 1'b0, inflight_to = 1'b0, prev_cv = 1'b0, prev_ov = 1'b0, prev_hs = 1'b0;
    int    timer = 0, rec = 0, issue_cyc = 0, push_edge = 0, ov_rise = 0, rst_cyc = 0;
    int    issues = 0, hs = 0, rst_pulses = 0;
    logic [15:0] l_seq = '0;
    rule_s l_rule = '0;
    logic  l_hit = 1'b0, l_to = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    always @(negedge clk) begin
        int   sz;
        res_t r;
        logic hsk;
        if (reset) begin
            chk("rst_in_ready", in_ready, 0);
            if (rst_q) begin
                chk("rst_cls_valid", cls_valid, 0);
                chk("rst_cls_packet", cls_packet, 0);
                chk("rst_cls_reset", cls_reset, 0);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_seq", out_seq, 0);
                chk("rst_out_rule", out_rule, 0);
                chk("rst_out_hit", out_hit, 0);
                chk("rst_out_timeout", out_timeout, 0);
                chk("rst_fifo_count", fifo_count, 0);
            end
            mq.delete(); eq.delete();
            wr_tag = '0; busy = 0; rec = 0; inflight_to = 0;
            prev_cv = 0; prev_ov = 0; prev_hs = 0;
            cls_ready = !stall;
        end else begin
            sz = mq.size();
            chk("fifo_count", fifo_count, sz);
            chk("in_ready", in_ready, sz != 8);
            chk("cls_reset", cls_reset, inflight_to && busy && (cyc == issue_cyc + TO));
            if (cls_reset) begin rst_pulses++; rst_cyc = cyc; end
            if (cls_valid) begin
                issues++;
                chk("cls_gap", prev_cv, 0);
                chk("issue_ready", cls_ready, 1);
                chk("issue_no_emit", out_valid, 0);
                if (sz == 0) chk("issue_empty", 1, 0);
                else begin
                    chk("cls_packet", cls_packet, mq[0].pkt);
                    r.seq  = mq[0].seq;
                    r.to   = never_ret;
                    r.rule = never_ret ? '0 : mode_rule;
                    r.hit  = !never_ret && (mode_rule.weight != 16'hFFFF);
                    eq.push_back(r);
                end
            end
            hsk = out_valid && out_ready;
            if (prev_ov && !prev_hs) chk("out_hold", out_valid, 1);
            if (out_valid) begin
                if (!prev_ov) ov_rise = cyc;
                if (eq.size() == 0) chk("out_unexpected", 1, 0);
                else begin
                    chk("out_seq", out_seq, eq[0].seq);
                    chk("out_rule", out_rule, eq[0].rule);
                    chk("out_hit", out_hit, eq[0].hit);
                    chk("out_timeout", out_timeout, eq[0].to);
                end
                if (hsk) begin
                    hs++;
                    l_seq = out_seq; l_rule = out_rule; l_hit = out_hit; l_to = out_timeout;
                    if (eq.size() > 0) void'(eq.pop_front());
                end
            end
            if (in_valid && sz != 8) begin
                mq.push_back('{seq: wr_tag, pkt: in_packet});
                wr_tag++;
                push_edge = cyc + 1;
            end
            if (cls_valid && sz != 0) void'(mq.pop_front());
            // behavioural classifier: busy from the pulse until its result (or abort)
            if (cls_valid) begin
                busy = 1; timer = 0; inflight_to = never_ret; issue_cyc = cyc; cls_rule = mode_rule;
            end else if (busy) begin
                timer++;
                if (inflight_to) begin
                    if (cls_reset) begin busy = 0; rec = rec_delay; end
                end else if (timer >= cls_delay) busy = 0;
            end else if (rec > 0) rec--;
            cls_ready = !(busy || rec > 0 || stall);
            prev_cv = cls_valid; prev_ov = out_valid; prev_hs = hsk;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input packet_s p);
        logic acc;
        int   b;
        in_valid = 1; in_packet = p; b = 0;
        do begin acc = in_ready; tick(1); b++; end while (!acc && b < 500);
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 0;
    endtask

    task automatic wait_hs(input int target);
        int b;
        b = 0;
        while (hs < target && b < 1000) begin tick(1); b++; end
        if (hs < target) chk("hs_timeout", hs, target);
    endtask

    function automatic packet_s mk(input int i);
        mk = '{src_ip: 32'h0A000000 + 32'(i), dst_ip: 32'hC0A80000 + 32'(i * 3),
               dst_port: 16'(80 + i), proto: 8'(6 + i)};
    endfunction

    initial begin
        int ic, ta, b;
        tick(3);
        reset = 0;
        tick(1);
        chk("post_rst_in_ready", in_ready, 1);

        // single packet, hit with weight 3, ready back 5 cycles after the pulse
        mode_rule = '{rule_id: 8'h11, action: 8'h02, weight: 16'd3};
        cls_delay = 5;
        send(mk(0));
        wait_hs(1);
        chk("t1_issue_lat", issue_cyc - push_edge, 1);
        chk("t1_out_lat", ov_rise - issue_cyc, 6);
        chk("t1_issues", issues, 1);
        chk("t1_seq", l_seq, 0);
        chk("t1_hit", l_hit, 1);
        chk("t1_weight", l_rule.weight, 3);
        chk("t1_to", l_to, 0);

        // no-rule sentinel
        mode_rule = '{rule_id: 8'h22, action: 8'h00, weight: 16'hFFFF};
        send(mk(1));
        wait_hs(2);
        chk("t2_hit", l_hit, 0);
        chk("t2_to", l_to, 0);
        chk("t2_seq", l_seq, 1);

        // fill the FIFO against a stalled classifier
        stall = 1;
        tick(2);
        mode_rule = '{rule_id: 8'h33, action: 8'h01, weight: 16'd7};
        cls_delay = 3;
        for (int i = 0; i < 8; i++) send(mk(10 + i));
        chk("t3_full_count", fifo_count, 8);
        chk("t3_full_ready", in_ready, 0);
        in_valid = 1; in_packet = mk(18);
        tick(3);
        chk("t3_held_count", fifo_count, 8);
        chk("t3_no_issue", issues, 2);
        stall = 0;
        send(mk(18));
        wait_hs(11);
        chk("t3_last_seq", l_seq, 10);

        // watchdog: classifier never comes back until aborted
        never_ret = 1; rec_delay = 4;
        ic = issues;
        send(mk(20));
        b = 0;
        while (issues == ic && b < 100) begin tick(1); b++; end
        chk("t4_issued", issues, ic + 1);
        never_ret = 0;
        ta = issue_cyc;
        mode_rule = '{rule_id: 8'h44, action: 8'h03, weight: 16'd9};
        send(mk(21));
        wait_hs(12);
        chk("t4_pulses", rst_pulses, 1);
        chk("t4_reset_offset", rst_cyc - ta, 16);
        chk("t4_to", l_to, 1);
        chk("t4_hit", l_hit, 0);
        chk("t4_rule", l_rule, 0);
        chk("t4_seq", l_seq, 11);
        wait_hs(13);
        chk("t4_reissue", issue_cyc - rst_cyc, 5);
        chk("t4_next_seq", l_seq, 12);
        chk("t4_next_to", l_to, 0);

        // downstream back-pressure during EMIT
        out_ready = 0;
        mode_rule = '{rule_id: 8'h55, action: 8'h04, weight: 16'd5};
        send(mk(30));
        send(mk(31));
        b = 0;
        while (!out_valid && b < 100) begin tick(1); b++; end
        chk("t5_valid", out_valid, 1);
        ic = issues;
        tick(10);
        chk("t5_no_issue", issues, ic);
        chk("t5_hold_valid", out_valid, 1);
        out_ready = 1;
        wait_hs(15);
        chk("t5_last_seq", l_seq, 14);

        // reset mid-flight with packets queued
        cls_delay = 40;
        for (int i = 0; i < 4; i++) send(mk(40 + i));
        tick(3);
        chk("t6_queued", fifo_count, 3);
        reset = 1;
        tick(2);
        reset = 0;
        tick(1);
        chk("t6_in_ready", in_ready, 1);
        chk("t6_count", fifo_count, 0);
        cls_delay = 3;
        send(mk(50));
        wait_hs(16);
        chk("t6_seq", l_seq, 0);

        tick(5);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/classify_dispatcher.md
# classify_dispatcher

Ingress stage that sits directly upstream of the tree classifier. It accepts packets from a streaming valid/ready source and buffers them in a small FIFO. It issues them one at a time to the classifier's single-cycle-pulse start interface, then captures the classifier's matched rule and returns it downstream as a tagged result with hit and timeout flags. A watchdog recovers from a classifier that never returns to ready.

## Interface
Parameters:
- FIFO_DEPTH, 8, packet buffer entries; power of two, ≥2
- SEQ_W, 16, width of per-packet sequence tag
- TIMEOUT_CYCLES, 512, max cycles from issue to classifier-ready before a forced abort

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  source packet valid
- in_ready  out  1  FIFO can accept
- in_packet  in  $bits(packet_s)  packet header
- cls_valid  out  1  one-cycle start pulse to classifier
- cls_packet  out  $bits(packet_s)  packet presented with cls_valid
- cls_ready  in  1  classifier idle/finished
- cls_rule  in  $bits(rule_s)  classifier matched-rule register
- cls_reset  out  1  one-cycle abort pulse, ORed with system reset at the classifier
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_seq  out  SEQ_W  tag of the packet this result belongs to
- out_rule  out  $bits(rule_s)  captured rule
- out_hit  out  1  1 = a rule matched
- out_timeout  out  1  1 = watchdog abort, out_rule = 0
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy

## Operation
- FIFO push on in_valid && in_ready. Each entry stores the packet plus a tag from a write counter, which wraps modulo 2^SEQ_W.
- in_ready = (count != FIFO_DEPTH). It depends on count only: when full, a same-cycle pop does not enable a push.
- FSM states and transitions:
  - IDLE → ISSUE when FIFO non-empty && cls_ready.
  - ISSUE: cls_valid=1 for exactly this cycle with cls_packet = FIFO head. Pop the head, latch its tag, clear the watchdog. → WAIT_BUSY.
  - WAIT_BUSY: wait for cls_ready==0, then → WAIT_DONE.
  - WAIT_DONE: on cls_ready==1, capture cls_rule into out_rule and set out_hit = (cls_rule.weight != all-ones). → EMIT.
  - Watchdog in WAIT_BUSY/WAIT_DONE: on reaching TIMEOUT_CYCLES, pulse cls_reset for one cycle, set out_timeout=1, out_hit=0, out_rule=0. → EMIT.
  - EMIT: out_valid=1, all out_* stable until out_ready. → IDLE on the handshake.
- Only one packet is in flight in the classifier at a time. Results leave in FIFO order; out_seq is strictly sequential mod 2^SEQ_W.
- Push and pop in the same cycle: count unchanged.
- The all-ones weight sentinel matches the classifier's per-packet weight initialisation, so it means "no rule".

## Timing
- Reset values: in_ready=0 while reset is high, 1 from the first cycle after. cls_valid=0, cls_packet=0, cls_reset=0, out_valid=0, out_seq=0, out_rule=0, out_hit=0, out_timeout=0, fifo_count=0, FSM=IDLE, tag counter=0.
- Reset mid-operation flushes the FIFO and abandons any in-flight result. cls_reset is not pulsed; the system reset already covers the classifier.
- Minimum latency, empty FIFO and idle classifier:
  - Packet accepted at edge N; cls_valid high in cycle N+1.
  - cls_valid is registered and never high two consecutive cycles.
  - out_valid rises the cycle after cls_ready is sampled high in WAIT_DONE.
- If cls_ready never drops after ISSUE, the watchdog still fires at TIMEOUT_CYCLES.
- After a timeout, IDLE waits for cls_ready==1 before the next ISSUE.
- out_valid never drops without out_ready; back-to-back results have at least one IDLE cycle between them.

## Structure
- Shared package: packet_s and rule_s (existing), plus new constants DISPATCH_FIFO_DEPTH, DISPATCH_SEQ_W, DISPATCH_TIMEOUT and the FSM enum dispatch_state_e.
- Sub-module: dispatch_fifo, a parameterized synchronous FIFO of {tag, packet} with count, full and empty outputs. The FSM, watchdog and result register stay in classify_dispatcher.

## Test plan
- One packet, classifier model returns ready 5 cycles after pulse with weight=3 → cls_valid is a single pulse at N+1; out_valid with out_seq=0, out_hit=1, out_rule.weight=3.
- Model returns weight=all-ones → out_hit=0, out_timeout=0, out_seq matches.
- Push 8 packets back-to-back with the classifier stalled → fifo_count=8, in_ready=0. A 9th in_valid is held off; all 8 results later emerge with seq 0..7 in order.
- Model never reasserts ready, TIMEOUT_CYCLES=16 → cls_reset pulses exactly once at cycle 16 after issue; result has out_timeout=1, out_hit=0, out_rule=0; the next packet issues after ready returns.
- Hold out_ready=0 for 10 cycles during EMIT → out_* stable, no new cls_valid; the handshake then releases the next issue.
- Reset asserted while in WAIT_DONE with 3 packets queued → all outputs return to reset values, fifo_count=0, and the first post-reset packet gets seq 0.
